// File: rtl/dcm_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dcm_lock_sequencer
// Brief  : Pulses DCM reset, waits for both locks, checks they stay stable,
//          then releases the system reset; bounded retries on lock failures.
// Rev    : 1.0 - initial release
// ============================================================================
module dcm_lock_sequencer #(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int STABLE_CYCLES  = 128,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED1,
  input  logic       LOCKED2,
  output logic       DCM_RST,
  output logic       RST_X_O,
  output logic       FAIL,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT
);

  localparam logic [2:0] S_DRST   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STAB   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAILED = 3'd4;

  localparam int MAX_A = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] DRST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  logic [1:0]       sync1_q, sync2_q;
  logic             lock_ok;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       retry_q, retry_d;
  logic             fail_evt;
  logic             dcm_rst_q, dcm_rst_d;
  logic             rst_x_q, rst_x_d;
  logic             fail_q, fail_d;

  assign lock_ok = sync1_q[1] & sync2_q[1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // State register, synchronizers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      state_q   <= S_DRST;
      cnt_q     <= '0;
      retry_q   <= 2'd0;
      dcm_rst_q <= 1'b1;
      rst_x_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync1_q   <= {sync1_q[0], LOCKED1};
      sync2_q   <= {sync2_q[0], LOCKED2};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dcm_rst_q <= dcm_rst_d;
      rst_x_q   <= rst_x_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    retry_d  = retry_q;
    fail_evt = 1'b0;
    case (state_q)
      S_DRST: begin
        if (cnt_q == DRST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (lock_ok) begin
          state_d = S_STAB;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          fail_evt = 1'b1;
        end
      end
      S_STAB: begin
        // Lock loss wins over completion on the final stability cycle
        if (!lock_ok) begin
          fail_evt = 1'b1;
        end else if (cnt_q == STAB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_ok) begin
          state_d = S_DRST;
          retry_d = 2'd0;
        end
      end
      S_FAILED: cnt_d = '0;
      default: begin
        state_d = S_DRST;
        cnt_d   = '0;
      end
    endcase
    if (fail_evt) begin
      cnt_d = '0;
      if (retry_q >= RETRY_MAX) begin
        state_d = S_FAILED;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = S_DRST;
      end
    end
  end

  // Outputs decoded from the next state so they are registered alongside it
  always_comb begin
    dcm_rst_d = 1'b0;
    rst_x_d   = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      S_DRST:   dcm_rst_d = 1'b1;
      S_RUN:    rst_x_d   = 1'b1;
      S_FAILED: begin
        dcm_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign DCM_RST   = dcm_rst_q;
  assign RST_X_O   = rst_x_q;
  assign FAIL      = fail_q;
  assign STATE     = state_q;
  assign RETRY_CNT = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_dcm_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dcm_lock_sequencer
// Brief  : Directed and randomized lock stimulus against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dcm_lock_sequencer;

  localparam int DRC = 4;
  localparam int LT  = 64;
  localparam int SC  = 16;
  localparam int MR  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       LOCKED1 = 1'b0;
  logic       LOCKED2 = 1'b0;
  logic       DCM_RST, RST_X_O, FAIL;
  logic [2:0] STATE;
  logic [1:0] RETRY_CNT;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Behavioural model: phase number, cycles elapsed in phase, retries,
  // and a two-deep history of the raw combined lock
  int m_phase, m_el, m_retry;
  bit m_ls0, m_ls1;

  dcm_lock_sequencer #(
    .DCM_RST_CYCLES(DRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOCKED1  (LOCKED1),
    .LOCKED2  (LOCKED2),
    .DCM_RST  (DCM_RST),
    .RST_X_O  (RST_X_O),
    .FAIL     (FAIL),
    .STATE    (STATE),
    .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_el    = 0;
    m_retry = 0;
    m_ls0   = 1'b0;
    m_ls1   = 1'b0;
  endtask

  task automatic model_fail();
    m_el = 0;
    if (m_retry == MR) m_phase = 4;
    else begin
      m_retry++;
      m_phase = 0;
    end
  endtask

  task automatic model_step(input bit raw_ok);
    bit ok;
    ok    = m_ls1;
    m_ls1 = m_ls0;
    m_ls0 = raw_ok;
    case (m_phase)
      0: begin
        m_el++;
        if (m_el == DRC) begin m_phase = 1; m_el = 0; end
      end
      1: begin
        if (ok) begin m_phase = 2; m_el = 0; end
        else begin
          m_el++;
          if (m_el == LT) model_fail();
        end
      end
      2: begin
        if (!ok) model_fail();
        else begin
          m_el++;
          if (m_el == SC) begin m_phase = 3; m_el = 0; end
        end
      end
      3: if (!ok) begin m_phase = 0; m_el = 0; m_retry = 0; end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".state"},   int'(STATE),     m_phase);
    check_eq({tag, ".retry"},   int'(RETRY_CNT), m_retry);
    check_eq({tag, ".dcm_rst"}, int'(DCM_RST),   int'(m_phase == 0 || m_phase == 4));
    check_eq({tag, ".rst_x"},   int'(RST_X_O),   int'(m_phase == 3));
    check_eq({tag, ".fail"},    int'(FAIL),      int'(m_phase == 4));
  endtask

  // Entered and left at a falling edge
  task automatic step(input bit a, input bit b, input string tag);
    LOCKED1 = a;
    LOCKED2 = b;
    @(posedge CLK);
    cyc++;
    model_step(a & b);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    #1 model_reset();
    check_outputs({tag, ".noedge"});
    @(negedge CLK);
    @(negedge CLK);
    check_outputs({tag, ".held"});
    RST = 1'b0;
  endtask

  initial begin
    int n;
    int rises[$];
    int rise_retry[$];
    bit prev_dcm;

    model_reset();
    #1 RST = 1'b1;
    #1 check_outputs("rst0");
    @(negedge CLK);
    @(negedge CLK);
    check_outputs("rst_hold");
    RST = 1'b0;

    // Normal lock
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, "drst");
      n++;
      if (!DCM_RST) break;
    end
    check_eq("dcm_rst_width", n, DRC);
    repeat (10) step(0, 0, "wait10");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, "lockup");
      n++;
      if (RST_X_O) break;
    end
    check_eq("run_latency_ok", int'(n >= 17 && n <= 19), 1);
    repeat (3) step(1, 1, "run");
    check_eq("run_state", int'(STATE), 3);

    // Loss of LOCKED1 in RUN
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, "loss");
      if (RST_X_O) n++;
    end
    check_eq("loss_rstx_cycles", int'(n <= 2), 1);
    for (int i = 0; i < 80 && m_phase != 3; i++) step(1, 1, "relock");
    check_eq("relock_state", int'(STATE), 3);
    check_eq("relock_retry", int'(RETRY_CNT), 0);

    // Drop of LOCKED2 in the middle of STAB
    for (int i = 0; i < 30 && m_phase != 1; i++) step(0, 0, "to_wait");
    for (int i = 0; i < 40 && !(m_phase == 2 && m_el == 8); i++) step(1, 1, "to_stab8");
    check_eq("reach_stab8", int'(STATE), 2);
    repeat (3) step(1, 0, "l2pulse");
    for (int i = 0; i < 10 && m_phase != 0; i++) step(1, 1, "drop");
    check_eq("drop_state", int'(STATE), 0);
    check_eq("drop_retry", int'(RETRY_CNT), 1);
    for (int i = 0; i < 80 && m_phase != 3; i++) step(1, 1, "drop_relock");
    check_eq("drop_relock_state", int'(STATE), 3);

    // Lock loss on the final STAB cycle
    for (int i = 0; i < 30 && m_phase != 1; i++) step(0, 0, "b_to_wait");
    for (int i = 0; i < 40 && !(m_phase == 2 && m_el == SC - 3); i++) step(1, 1, "b_stab");
    repeat (3) step(0, 0, "b_fall");
    check_eq("bnd_stab_last", int'(STATE), 0);
    check_eq("bnd_stab_retry", int'(RETRY_CNT), 1);

    // Lock arriving on the final WAIT cycle
    for (int i = 0; i < 100 && !(m_phase == 1 && m_el == LT - 3); i++) step(0, 0, "b_wait");
    repeat (3) step(1, 1, "b_rise");
    check_eq("bnd_wait_last", int'(STATE), 2);
    check_eq("bnd_wait_retry", int'(RETRY_CNT), 1);
    for (int i = 0; i < 40 && m_phase != 3; i++) step(1, 1, "b_run");

    // Timeout retries until FAILED
    prev_dcm = DCM_RST;
    for (int i = 0; i < 400 && m_phase != 4; i++) begin
      step(0, 0, "timeout");
      if (DCM_RST && !prev_dcm && m_phase != 4) begin
        rises.push_back(cyc);
        rise_retry.push_back(int'(RETRY_CNT));
      end
      prev_dcm = DCM_RST;
    end
    check_eq("failed_state", int'(STATE), 4);
    check_eq("drst_pulses", rises.size(), 3);
    for (int k = 0; k < rises.size(); k++) begin
      check_eq("pulse_retry", rise_retry[k], k);
      if (k > 0) check_eq("pulse_spacing", rises[k] - rises[k-1], DRC + LT);
    end
    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "failed_hold");
    check_eq("failed_hold_fail", int'(FAIL), 1);
    async_reset("rst_failed");
    check_eq("rst_failed_fail", int'(FAIL), 0);

    // Reset during WAIT
    for (int i = 0; i < 30 && !(m_phase == 1 && m_el == 10); i++) step(0, 0, "w_rst");
    async_reset("rst_wait");

    // Randomized lock bursts with occasional asynchronous resets
    for (int k = 0; k < 150; k++) begin
      bit a, b;
      int len;
      a   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) != 0);
      len = int'($urandom_range(1, 40));
      for (int j = 0; j < len; j++) step(a, b, "rnd");
      if ($urandom_range(0, 15) == 0) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcm_lock_sequencer.md
DCM_LOCK_SEQUENCER -- requirements
Module: dcm_lock_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be exactly:
- DCM_RST_CYCLES, 4: cycles DCM_RST is held high per attempt.
- LOCK_TIMEOUT, 1024: cycles allowed for both locks per attempt.
- STABLE_CYCLES, 128: cycles both locks must stay continuously high before release.
- MAX_RETRY, 3: failed attempts tolerated before FAIL.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning), SHALL be exactly:
- CLK, in, 1: free-running board clock, not DCM-derived.
- RST, in, 1: asynchronous active-high reset.
- LOCKED1, in, 1: DCM 1 lock, asynchronous to CLK.
- LOCKED2, in, 1: DCM 2 lock, asynchronous to CLK.
- DCM_RST, out, 1: active-high reset to both DCMs.
- RST_X_O, out, 1: active-low system reset.
- FAIL, out, 1: retries exhausted.
- STATE, out, 3: current state code.
- RETRY_CNT, out, 2: failed attempts in the current sequence.

Function
REQ-004 LOCKED1 and LOCKED2 SHALL each pass through a 2-flop synchronizer; lock_ok = AND of both synchronized bits.
REQ-005 States and STATE codes SHALL be: DRST=0, WAIT=1, STAB=2, RUN=3, FAILED=4; codes 5-7 SHALL return to DRST on the next edge.
REQ-006 DRST: DCM_RST=1, RST_X_O=0; after exactly DCM_RST_CYCLES cycles -> WAIT, with the cycle counter cleared.
REQ-007 WAIT: DCM_RST=0, RST_X_O=0; lock_ok -> STAB, counter cleared; LOCK_TIMEOUT cycles without lock_ok -> timeout failure.
REQ-008 STAB: lock_ok held for STABLE_CYCLES consecutive cycles -> RUN; any lock_ok=0 cycle -> drop failure.
REQ-009 RUN: RST_X_O=1, DCM_RST=0; lock_ok=0 -> DRST with RETRY_CNT cleared to 0, and RST_X_O low on the next edge.
REQ-010 On a failure (timeout or drop): if RETRY_CNT == MAX_RETRY -> FAILED; otherwise RETRY_CNT += 1 -> DRST.
REQ-011 FAILED: DCM_RST=1, RST_X_O=0, FAIL=1; the state is held until RST.
REQ-012 All outputs SHALL be registered and glitch-free.
REQ-013 RST_X_O SHALL be 1 only in RUN.
REQ-014 Cycle counters SHALL be wide enough for the largest parameter and SHALL saturate, never wrap.
REQ-015 RETRY_CNT SHALL never exceed MAX_RETRY; MAX_RETRY > 3 is illegal.
REQ-016 Lock loss on the same cycle STAB completes SHALL be treated as a drop failure, not a transition to RUN.

Reset
REQ-017 While RST=1: STATE=DRST, DCM_RST=1, RST_X_O=0, FAIL=0, RETRY_CNT=0, counters=0, synchronizers=0.
REQ-018 Asserting RST mid-operation, including in RUN or FAILED, SHALL force the REQ-017 values asynchronously.
REQ-019 After RST deasserts, DCM_RST SHALL stay high for exactly DCM_RST_CYCLES rising edges.

Verification (DCM_RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, MAX_RETRY=2)
REQ-020 Normal lock: release RST, raise both locks 10 cycles after DCM_RST falls -> DCM_RST high 4 cycles; RST_X_O rises 2+16 (+/-1) cycles after the locks rise; STATE=3.
REQ-021 Timeout retries: locks held low -> 3 DRST pulses spaced 4+64 cycles; RETRY_CNT goes 0,1,2; then FAIL=1, STATE=4, DCM_RST=1, held for 1000 cycles.
REQ-022 Drop in STAB: LOCKED2 pulses low for 3 cycles at STAB count 8 -> return to DRST, RETRY_CNT=1, RST_X_O stays 0; a later clean lock reaches RUN.
REQ-023 Loss in RUN: drop LOCKED1 -> RST_X_O=0 within 3 cycles of the drop, DCM_RST pulses for 4 cycles, RETRY_CNT=0, re-lock reaches RUN.
REQ-024 Reset mid-op: assert RST during WAIT and during FAILED -> outputs take the REQ-017 values without a clock edge; FAIL clears.
REQ-025 Boundary: lock_ok falls exactly on STAB count 15 -> DRST, not RUN; lock_ok rises on WAIT count 63 -> STAB, not a timeout.
